reg_wb_scheduler: RTL and testbench
===================================

Name: reg_wb_scheduler

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and memory-load results.
- Arbitrates with load priority. A starvation counter guarantees the ALU is eventually granted.
- Keeps a busy scoreboard of destination registers, so issue logic can detect RAW hazards on both register-file read indices.
- Supplies forwarding hits for the write being committed this cycle.
- Sits between execute/memory stages and reg_manager. Its wb_* outputs drive reg_manager's w_data/w_enable and write index.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- IDX_W, 5, register index width.
- REG_W, 16, register data width.
- STARVE_LIMIT, 4, consecutive denied ALU cycles before the ALU wins over load.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- alu_valid, in, 1, ALU writeback request.
- alu_index, in, IDX_W, ALU destination register.
- alu_data, in, REG_W, ALU result.
- alu_ready, out, 1, ALU request accepted this cycle.
- ld_valid, in, 1, load writeback request.
- ld_index, in, IDX_W, load destination register.
- ld_data, in, REG_W, load data.
- ld_ready, out, 1, load request accepted this cycle.
- wb_hold, in, 1, blocks all grants.
- mark_valid, in, 1, issue stage reserves a destination register.
- mark_index, in, IDX_W, register to mark busy.
- query_index1, in, IDX_W, first source register (same value as reg_index1).
- query_index2, in, IDX_W, second source register (same value as reg_index2).
- query_busy1, out, 1, source 1 is unavailable (RAW stall).
- query_busy2, out, 1, source 2 is unavailable (RAW stall).
- fwd_hit1, out, 1, source 1 must take wb_data this cycle.
- fwd_hit2, out, 1, source 2 must take wb_data this cycle.
- wb_enable, out, 1, register-file write strobe.
- wb_index, out, IDX_W, register-file write index.
- wb_data, out, REG_W, register-file write data.
- busy_vec, out, NUM_REGS, scoreboard state for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is low:
  - wb_enable, wb_index, wb_data, busy_vec and the starvation counter are 0.
  - alu_ready and ld_ready are 0.
  - A request pending when reset asserts is dropped; the requester re-presents it after reset.
- Handshake:
  - A transfer occurs on a cycle with valid && ready.
  - Once valid is raised, index and data stay stable until the transfer.
  - ready is combinational from the valid inputs, wb_hold and the counter. It never depends on outputs combinationally derived from ready.
- Grant rule:
  - wb_hold = 1: both readies are 0.
  - Otherwise, only one source valid: that source is granted.
  - Both valid and counter == STARVE_LIMIT: ALU is granted.
  - Both valid otherwise: load is granted.
  - At most one ready is high per cycle.
- Starvation counter:
  - Clears on an ALU transfer.
  - Otherwise increments, saturating at STARVE_LIMIT, on each cycle with alu_valid && !alu_ready. This includes wb_hold cycles.
  - Holds its value when alu_valid = 0.
- Latency:
  - A transfer at edge t registers wb_enable = 1 with the granted index and data, visible after edge t.
  - The register file writes at edge t+1. One write per cycle; back-to-back transfers produce back-to-back writes.
  - wb_enable is 0 on the cycle after a no-transfer cycle; wb_index and wb_data hold their last values.
- Scoreboard:
  - mark_valid sets busy[mark_index] at the edge.
  - wb_enable clears busy[wb_index] at the edge.
  - Simultaneous mark and clear of the same index: mark wins, bit stays 1 (new producer).
  - Marking an already-busy index leaves it at 1; upstream guarantees a single outstanding producer per register.
- Hazard and forward logic, for each n in {1, 2}:
  - fwd_hitn = wb_enable && (wb_index == query_indexn).
  - query_busyn = busy[query_indexn] && !fwd_hitn.
  - A mark issued this cycle does not affect queries until the next cycle.
  - Register 0 is an ordinary register: it is scoreboarded and writable.
- Same-index writes from both sources in one cycle: arbitration as above; the loser writes on a later cycle. Final value ordering is upstream's responsibility.

Decomposition:
- Package reg_pkg holds NUM_REGS, IDX_W and REG_W.
- Sub-module reg_scoreboard holds the busy vector, mark/clear update, and query/forward comparators for two query ports.
- Arbitration, the starvation counter and the wb output registers stay at top level.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream with ld_valid = 1 → readies 0, wb_enable 0, busy_vec 0, counter 0. After release, the load writes on the second edge.
- Single ALU write: alu_valid with index 7, data 16'hBEEF, nothing else active → alu_ready = 1. Next cycle wb_enable = 1, wb_index = 7, wb_data = 16'hBEEF, then wb_enable = 0.
- Contention: ld_valid and alu_valid held high continuously → load wins 4 cycles, ALU is granted on the 5th, and the pattern repeats.
- Scoreboard: mark_valid with index 3, then query_index1 = 3 → query_busy1 = 1. When the ALU write to 3 is on wb_* → fwd_hit1 = 1 and query_busy1 = 0. After that edge, busy_vec[3] = 0.
- Mark and clear collision: mark_valid on index 5 on the same cycle as wb_enable with wb_index = 5 → busy_vec[5] remains 1.
- Hold: wb_hold = 1 for 6 cycles with alu_valid = 1 → no grants and the counter saturates at 4. After wb_hold drops with ld_valid = 1 also present, the ALU is granted first.

Source files
------------

// File: rtl/reg_pkg.sv
// reg_pkg: shared sizes, types and helpers for the register writeback scheduler.
package reg_pkg;
    localparam int NUM_REGS     = 32;
    localparam int IDX_W        = 5;
    localparam int REG_W        = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [REG_W-1:0]    data_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [NUM_REGS-1:0] vec_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LD} gnt_e;

    function automatic vec_t idx_mask(input idx_t idx, input logic en);
        vec_t one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return en ? (one << idx) : '0;
    endfunction
endpackage

// File: rtl/reg_wb_scheduler_if.sv
// reg_wb_if: ALU and load writeback request channels (valid/ready with index and data).
interface reg_wb_if import reg_pkg::*; ();
    logic  alu_valid;
    idx_t  alu_index;
    data_t alu_data;
    logic  alu_ready;
    logic  ld_valid;
    idx_t  ld_index;
    data_t ld_data;
    logic  ld_ready;

    modport master (
        output alu_valid, alu_index, alu_data, ld_valid, ld_index, ld_data,
        input  alu_ready, ld_ready
    );
    modport slave (
        input  alu_valid, alu_index, alu_data, ld_valid, ld_index, ld_data,
        output alu_ready, ld_ready
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per destination register plus two RAW query/forward ports.
module reg_scoreboard import reg_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic mark_valid,
    input  idx_t mark_index,
    input  logic clr_valid,
    input  idx_t clr_index,
    input  idx_t query_index1,
    input  idx_t query_index2,
    output logic query_busy1,
    output logic query_busy2,
    output logic fwd_hit1,
    output logic fwd_hit2,
    output vec_t busy_vec
);
    vec_t busy_q, busy_d;

    // Mark applied after clear so a new producer wins a same-index collision.
    always_comb begin
        busy_d = (busy_q & ~idx_mask(clr_index, clr_valid)) | idx_mask(mark_index, mark_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign fwd_hit1    = clr_valid && (clr_index == query_index1);
    assign fwd_hit2    = clr_valid && (clr_index == query_index2);
    assign query_busy1 = busy_q[query_index1] && !fwd_hit1;
    assign query_busy2 = busy_q[query_index2] && !fwd_hit2;
    assign busy_vec    = busy_q;
endmodule

// File: rtl/reg_wb_scheduler.sv
// reg_wb_scheduler: load-priority arbiter with ALU anti-starvation for the single
// register-file write port, plus a destination scoreboard for RAW detection.
module reg_wb_scheduler import reg_pkg::*; (
    input  logic     clk,
    input  logic     rst_n,
    reg_wb_if.slave  bus,
    input  logic     wb_hold,
    input  logic     mark_valid,
    input  idx_t     mark_index,
    input  idx_t     query_index1,
    input  idx_t     query_index2,
    output logic     query_busy1,
    output logic     query_busy2,
    output logic     fwd_hit1,
    output logic     fwd_hit2,
    output logic     wb_enable,
    output idx_t     wb_index,
    output data_t    wb_data,
    output vec_t     busy_vec
);
    cnt_t  cnt_q, cnt_d;
    logic  wb_en_q, wb_en_d;
    idx_t  wb_idx_q, wb_idx_d;
    data_t wb_data_q, wb_data_d;
    gnt_e  gnt;
    logic  starved;

    assign starved = (cnt_q == cnt_t'(STARVE_LIMIT));

    // Readies depend only on the valids, hold, reset and the counter.
    always_comb begin
        gnt = (!rst_n || wb_hold)                            ? GNT_NONE :
              (bus.alu_valid && (!bus.ld_valid || starved))  ? GNT_ALU  :
              bus.ld_valid                                   ? GNT_LD   : GNT_NONE;
    end

    assign bus.alu_ready = (gnt == GNT_ALU);
    assign bus.ld_ready  = (gnt == GNT_LD);

    always_comb begin
        cnt_d     = cnt_q;
        if (gnt == GNT_ALU)                 cnt_d = '0;
        else if (bus.alu_valid && !starved) cnt_d = cnt_q + cnt_t'(1);
        wb_en_d   = (gnt != GNT_NONE);
        wb_idx_d  = (gnt == GNT_ALU) ? bus.alu_index : (gnt == GNT_LD) ? bus.ld_index : wb_idx_q;
        wb_data_d = (gnt == GNT_ALU) ? bus.alu_data  : (gnt == GNT_LD) ? bus.ld_data  : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_enable = wb_en_q;
    assign wb_index  = wb_idx_q;
    assign wb_data   = wb_data_q;

    reg_scoreboard u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .mark_valid   (mark_valid),
        .mark_index   (mark_index),
        .clr_valid    (wb_en_q),
        .clr_index    (wb_idx_q),
        .query_index1 (query_index1),
        .query_index2 (query_index2),
        .query_busy1  (query_busy1),
        .query_busy2  (query_busy2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .busy_vec     (busy_vec)
    );
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb_reg_wb_scheduler: directed scenario tasks with hand-computed expectations.
module tb_reg_wb_scheduler;
    import reg_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  wb_hold, mark_valid;
    idx_t  mark_index, query_index1, query_index2;
    logic  query_busy1, query_busy2, fwd_hit1, fwd_hit2, wb_enable;
    idx_t  wb_index;
    data_t wb_data;
    vec_t  busy_vec;
    int    errors = 0;
    int    checks = 0;

    reg_wb_if bus ();

    reg_wb_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .wb_hold      (wb_hold),
        .mark_valid   (mark_valid),
        .mark_index   (mark_index),
        .query_index1 (query_index1),
        .query_index2 (query_index2),
        .query_busy1  (query_busy1),
        .query_busy2  (query_busy2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .wb_enable    (wb_enable),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_index = '0; bus.alu_data = '0;
        bus.ld_valid  = 0; bus.ld_index  = '0; bus.ld_data  = '0;
        wb_hold = 0; mark_valid = 0; mark_index = '0;
        query_index1 = '0; query_index2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        step(); step();
        rst_n = 1;
        step();
        bus.ld_valid = 1; bus.ld_index = 5'd9; bus.ld_data = 16'h1234;
        bus.alu_valid = 1; bus.alu_index = 5'd1; bus.alu_data = 16'h0001;
        mark_valid = 1; mark_index = 5'd10;
        step();
        mark_valid = 0;
        step();
        #2 rst_n = 0;
        bus.alu_valid = 0;
        #1;
        checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.alu_ready, bus.ld_ready}); end
        checks++; if (wb_enable !== 1'b0) begin errors++; $display("FAIL reset_wb_enable: got %b want 0", wb_enable); end
        checks++; if ({wb_index, wb_data} !== 21'h0) begin errors++; $display("FAIL reset_wb_regs: got idx %0d data %h want 0 0", wb_index, wb_data); end
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec); end
        checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL reset_counter: got %0d want 0", dut.cnt_q); end
        #1 rst_n = 1;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.ld_ready); end
        step();
        bus.ld_valid = 0;
        checks++; if ({wb_enable, wb_index, wb_data} !== {1'b1, 5'd9, 16'h1234}) begin errors++; $display("FAIL reset_reload: got en %b idx %0d data %h want 1 9 1234", wb_enable, wb_index, wb_data); end
        step();
        checks++; if (wb_enable !== 1'b0) begin errors++; $display("FAIL reset_reload_done: got %b want 0", wb_enable); end
    endtask

    task automatic test_single_alu();
        idle();
        bus.alu_valid = 1; bus.alu_index = 5'd7; bus.alu_data = 16'hBEEF;
        #1;
        checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b10) begin errors++; $display("FAIL alu_ready: got %b want 10", {bus.alu_ready, bus.ld_ready}); end
        step();
        bus.alu_valid = 0;
        checks++; if ({wb_enable, wb_index, wb_data} !== {1'b1, 5'd7, 16'hBEEF}) begin errors++; $display("FAIL alu_write: got en %b idx %0d data %h want 1 7 beef", wb_enable, wb_index, wb_data); end
        step();
        checks++; if ({wb_enable, wb_index, wb_data} !== {1'b0, 5'd7, 16'hBEEF}) begin errors++; $display("FAIL alu_write_done: got en %b idx %0d data %h want 0 7 beef", wb_enable, wb_index, wb_data); end
    endtask

    task automatic test_contention();
        logic exp_alu;
        idle();
        bus.ld_valid  = 1; bus.ld_index  = 5'd2; bus.ld_data  = 16'h1111;
        bus.alu_valid = 1; bus.alu_index = 5'd4; bus.alu_data = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            exp_alu = (i == 4) || (i == 9);
            #1;
            checks++; if ({bus.alu_ready, bus.ld_ready} !== {exp_alu, !exp_alu}) begin errors++; $display("FAIL contention_grant[%0d]: got %b want %b", i, {bus.alu_ready, bus.ld_ready}, {exp_alu, !exp_alu}); end
            step();
            checks++; if (wb_index !== (exp_alu ? 5'd4 : 5'd2)) begin errors++; $display("FAIL contention_wb_index[%0d]: got %0d want %0d", i, wb_index, exp_alu ? 4 : 2); end
        end
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        idle();
        mark_valid = 1; mark_index = 5'd3;
        step();
        mark_valid = 0;
        query_index1 = 5'd3;
        #1;
        checks++; if ({busy_vec[3], query_busy1, fwd_hit1} !== 3'b110) begin errors++; $display("FAIL sb_busy: got %b want 110", {busy_vec[3], query_busy1, fwd_hit1}); end
        bus.alu_valid = 1; bus.alu_index = 5'd3; bus.alu_data = 16'h0333;
        step();
        bus.alu_valid = 0;
        checks++; if ({fwd_hit1, query_busy1, busy_vec[3]} !== 3'b101) begin errors++; $display("FAIL sb_forward: got %b want 101", {fwd_hit1, query_busy1, busy_vec[3]}); end
        checks++; if ({fwd_hit2, query_busy2} !== 2'b00) begin errors++; $display("FAIL sb_port2_idle: got %b want 00", {fwd_hit2, query_busy2}); end
        step();
        checks++; if ({busy_vec[3], fwd_hit1, query_busy1} !== 3'b000) begin errors++; $display("FAIL sb_cleared: got %b want 000", {busy_vec[3], fwd_hit1, query_busy1}); end
    endtask

    task automatic test_collision();
        idle();
        query_index2 = 5'd5;
        mark_valid = 1; mark_index = 5'd5;
        step();
        mark_valid = 0;
        checks++; if (query_busy2 !== 1'b1) begin errors++; $display("FAIL coll_busy2: got %b want 1", query_busy2); end
        bus.alu_valid = 1; bus.alu_index = 5'd5; bus.alu_data = 16'h0555;
        step();
        bus.alu_valid = 0;
        mark_valid = 1; mark_index = 5'd5;
        #1;
        checks++; if ({wb_enable, wb_index, fwd_hit2, query_busy2} !== {1'b1, 5'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL coll_forward: got en %b idx %0d hit %b busy %b want 1 5 1 0", wb_enable, wb_index, fwd_hit2, query_busy2); end
        step();
        mark_valid = 0;
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL coll_mark_wins: got %b want 1", busy_vec[5]); end
    endtask

    task automatic test_hold();
        idle();
        wb_hold = 1;
        bus.alu_valid = 1; bus.alu_index = 5'd6; bus.alu_data = 16'h0666;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b00) begin errors++; $display("FAIL hold_grant[%0d]: got %b want 00", i, {bus.alu_ready, bus.ld_ready}); end
            step();
            checks++; if (wb_enable !== 1'b0) begin errors++; $display("FAIL hold_wb_enable[%0d]: got %b want 0", i, wb_enable); end
        end
        checks++; if (dut.cnt_q !== 3'd4) begin errors++; $display("FAIL hold_counter: got %0d want 4", dut.cnt_q); end
        wb_hold = 0;
        bus.ld_valid = 1; bus.ld_index = 5'd8; bus.ld_data = 16'h0888;
        #1;
        checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b10) begin errors++; $display("FAIL hold_release_grant: got %b want 10", {bus.alu_ready, bus.ld_ready}); end
        step();
        bus.alu_valid = 0;
        checks++; if ({wb_enable, wb_index, wb_data} !== {1'b1, 5'd6, 16'h0666}) begin errors++; $display("FAIL hold_alu_write: got en %b idx %0d data %h want 1 6 0666", wb_enable, wb_index, wb_data); end
        checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL hold_counter_clear: got %0d want 0", dut.cnt_q); end
        #1;
        checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b01) begin errors++; $display("FAIL hold_ld_grant: got %b want 01", {bus.alu_ready, bus.ld_ready}); end
        step();
        bus.ld_valid = 0;
        checks++; if ({wb_enable, wb_index, wb_data} !== {1'b1, 5'd8, 16'h0888}) begin errors++; $display("FAIL hold_ld_write: got en %b idx %0d data %h want 1 8 0888", wb_enable, wb_index, wb_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_scoreboard();
        test_collision();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
